hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Control end of the ID/EX pipeline register: watches the decode-stage operands and the
//  fields the ID/EX and EX/MEM registers hand to EX/MEM. Drives PC/IF-ID hold, IF-ID
//  flush and ID/EX bubble insertion so the register only latches legal instructions.
//  Resolves load-use stalls and branch/jump redirect flushes with a small FSM.
// PARAMETERS
//  LOAD_STALL_CYCLES  1   bubbles inserted per load-use hazard (>=1)
//  FLUSH_CYCLES       1   cycles IF/ID flush is held after a redirect (>=1)
//  PERF_W             16  width of stall-cycle performance counter
// PORTS
//  CLK            in   1   clock; all state updates on negedge CLK, same edge as the pipe registers
//  RSTn           in   1   asynchronous active-low reset
//  rs_id          in   5   ID-stage source register A
//  rt_id          in   5   ID-stage source register B
//  uses_rt_id     in   1   ID instruction reads rt
//  Wreg_addr_ex   in   5   dest reg of instruction in EX (ID/EX output)
//  RegWrite_ex    in   1   EX instruction writes reg file
//  MemRead_ex     in   1   EX instruction is a load
//  Wreg_addr_mem  in   5   dest reg of instruction in MEM
//  RegWrite_mem   in   1   MEM instruction writes reg file
//  redirect_ex    in   1   branch taken or JtoPC resolved in EX
//  PC_write       out  1   1 = PC may advance
//  IFID_write     out  1   1 = IF/ID may latch
//  IFID_flush     out  1   1 = IF/ID loads a NOP
//  IDEX_bubble    out  1   1 = ID/EX control fields (RegWrite,MemWrite,MemRead,Branch,JtoPC) forced 0
//  stall_cycles   out  PERF_W  saturating count of cycles with PC_write=0
// BEHAVIOUR
//  - Reset: state=RUN, cnt=0, stall_cycles=0; outputs PC_write=1, IFID_write=1, IFID_flush=0,
//    IDEX_bubble=0 while RSTn low. Reset mid-stall/flush aborts immediately to RUN.
//  - hz = RegWrite_ex & MemRead_ex & Wreg_addr_ex!=0 &
//         (Wreg_addr_ex==rs_id | (uses_rt_id & Wreg_addr_ex==rt_id)). $zero never hazards.
//  - Outputs are combinational from state and current inputs (zero latency); state/cnt registered.
//  - RUN: redirect_ex -> IFID_flush=1, IDEX_bubble=1, PC_write=1; if FLUSH_CYCLES>1 go FLUSH,
//    cnt=FLUSH_CYCLES-1. Else hz -> PC_write=0, IFID_write=0, IDEX_bubble=1; if
//    LOAD_STALL_CYCLES>1 go STALL, cnt=LOAD_STALL_CYCLES-1. Else all pass-through.
//  - STALL: PC_write=0, IFID_write=0, IDEX_bubble=1; cnt-- each cycle; cnt==1 -> RUN next.
//  - FLUSH: IFID_flush=1, IDEX_bubble=1, PC_write=1; cnt--; cnt==1 -> RUN next.
//  - Simultaneous redirect and hz: redirect wins (ID instruction is wrong-path, discard it).
//    redirect_ex in STALL: go FLUSH (cnt reloaded), flush outputs that cycle.
//    redirect_ex in FLUSH: cnt reloaded to FLUSH_CYCLES-1, stay FLUSH (RUN if FLUSH_CYCLES==1).
//  - stall_cycles increments when PC_write=0, saturates at all-ones (no wrap).
// CONFIGURATION
//  HAZARD_FORWARD_EN defined: adds outputs fwdA_sel, fwdB_sel [1:0] (00 reg file, 01 MEM result,
//    10 EX result; EX beats MEM when both match), adds inputs rs_ex, rt_ex [4:0]; hz as above.
//  Undefined: no forwarding ports; hz additionally true for any RegWrite_ex or RegWrite_mem
//    nonzero dest matching rs_id/rt_id (uses_rt-gated); stall repeats while the match persists.
// STRUCTURE
//  Shared package: state enum {RUN,STALL,FLUSH}, REG_ZERO=5'd0, fwd select codes.
//  Optional sub-module hazard_cmp (pure register-match compare), instanced for rs and rt.
// TESTING
//  1 lw $2 in EX (MemRead_ex=1,Wreg_addr_ex=2), rs_id=2 -> PC_write=0,IFID_write=0,IDEX_bubble=1 one cycle, then RUN.
//  2 Same with Wreg_addr_ex=0 or uses_rt_id=0 & rt_id=2,rs_id=5 -> no stall, all pass-through.
//  3 redirect_ex=1 with hz=1 same cycle -> IFID_flush=1,IDEX_bubble=1,PC_write=1; no stall.
//  4 LOAD_STALL_CYCLES=3: load-use -> exactly 3 cycles PC_write=0; stall_cycles +=3.
//  5 RSTn low during STALL (cnt=2) -> outputs pass-through immediately, state RUN, counter 0.
//  6 Forward build: RegWrite_ex=1,Wreg_addr_ex=4,rs_ex=4, also MEM dest 4 -> fwdA_sel=10;
//    non-forward build same case -> stall until producer leaves MEM.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
// Forwarding select codes are only consumed when HAZARD_FORWARD_EN is defined.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  // The younger producer (EX) holds the newest value, so it takes priority over MEM.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex) begin
      return FWD_EX;
    end
    if (hit_mem) begin
      return FWD_MEM;
    end
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// Register-match compare: a producer stage that writes a nonzero register equal to src_addr.
// Writes to $zero are discarded by the register file, so they never create a dependency.
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_addr,
  input  logic [4:0] dst_addr,
  input  logic       dst_we,
  output logic       hit
);

  assign hit = dst_we && (dst_addr != REG_ZERO) && (dst_addr == src_addr);

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall / redirect flush controller for the ID/EX register (state updates on negedge CLK).
// Optional feature macro HAZARD_FORWARD_EN adds EX/MEM forwarding selects; otherwise all RAW hazards stall.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int PERF_W            = 16
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [4:0]        rs_id,
  input  logic [4:0]        rt_id,
  input  logic              uses_rt_id,
  input  logic [4:0]        Wreg_addr_ex,
  input  logic              RegWrite_ex,
  input  logic              MemRead_ex,
  input  logic [4:0]        Wreg_addr_mem,
  input  logic              RegWrite_mem,
  input  logic              redirect_ex,
`ifdef HAZARD_FORWARD_EN
  input  logic [4:0]        rs_ex,
  input  logic [4:0]        rt_ex,
  output logic [1:0]        fwdA_sel,
  output logic [1:0]        fwdB_sel,
`endif
  output logic              PC_write,
  output logic              IFID_write,
  output logic              IFID_flush,
  output logic              IDEX_bubble,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int CNT_MAX = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_q, stall_d;

  logic rs_hit_ex, rt_hit_ex;
  logic load_hz, hz;
  logic do_stall, do_flush;

  hazard_cmp u_cmp_rs_ex (
    .src_addr (rs_id),
    .dst_addr (Wreg_addr_ex),
    .dst_we   (RegWrite_ex),
    .hit      (rs_hit_ex)
  );

  hazard_cmp u_cmp_rt_ex (
    .src_addr (rt_id),
    .dst_addr (Wreg_addr_ex),
    .dst_we   (RegWrite_ex),
    .hit      (rt_hit_ex)
  );

  assign load_hz = RegWrite_ex && MemRead_ex && (rs_hit_ex || (uses_rt_id && rt_hit_ex));

`ifdef HAZARD_FORWARD_EN
  logic fa_hit_ex, fa_hit_mem, fb_hit_ex, fb_hit_mem;

  hazard_cmp u_cmp_fa_ex  (.src_addr(rs_ex), .dst_addr(Wreg_addr_ex),  .dst_we(RegWrite_ex),  .hit(fa_hit_ex));
  hazard_cmp u_cmp_fa_mem (.src_addr(rs_ex), .dst_addr(Wreg_addr_mem), .dst_we(RegWrite_mem), .hit(fa_hit_mem));
  hazard_cmp u_cmp_fb_ex  (.src_addr(rt_ex), .dst_addr(Wreg_addr_ex),  .dst_we(RegWrite_ex),  .hit(fb_hit_ex));
  hazard_cmp u_cmp_fb_mem (.src_addr(rt_ex), .dst_addr(Wreg_addr_mem), .dst_we(RegWrite_mem), .hit(fb_hit_mem));

  assign fwdA_sel = fwd_sel(fa_hit_ex, fa_hit_mem);
  assign fwdB_sel = fwd_sel(fb_hit_ex, fb_hit_mem);
  assign hz       = load_hz;
`else
  logic rs_hit_mem, rt_hit_mem;

  hazard_cmp u_cmp_rs_mem (.src_addr(rs_id), .dst_addr(Wreg_addr_mem), .dst_we(RegWrite_mem), .hit(rs_hit_mem));
  hazard_cmp u_cmp_rt_mem (.src_addr(rt_id), .dst_addr(Wreg_addr_mem), .dst_we(RegWrite_mem), .hit(rt_hit_mem));

  // Without a bypass network every in-flight producer must drain before its consumer may issue.
  assign hz = load_hz || rs_hit_ex || rs_hit_mem || (uses_rt_id && (rt_hit_ex || rt_hit_mem));
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    do_stall = 1'b0;
    do_flush = 1'b0;

    unique case (state_q)
      RUN: begin
        if (redirect_ex) begin
          do_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end
        end else if (hz) begin
          do_stall = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = STALL_RELOAD;
          end
        end
      end
      STALL: begin
        if (redirect_ex) begin
          do_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else begin
            state_d = RUN;
          end
        end else begin
          do_stall = 1'b1;
          cnt_d    = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        do_flush = 1'b1;
        if (redirect_ex) begin
          if (FLUSH_CYCLES > 1) begin
            cnt_d = FLUSH_RELOAD;
          end else begin
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    // Outputs are combinational, so reset must also mask hazards seen on the live inputs.
    if (!RSTn) begin
      do_stall = 1'b0;
      do_flush = 1'b0;
    end

    PC_write    = !do_stall;
    IFID_write  = !do_stall;
    IFID_flush  = do_flush;
    IDEX_bubble = do_flush || do_stall;

    stall_d = stall_q;
    if (!PC_write && (stall_q != {PERF_W{1'b1}})) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  always_ff @(negedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: DUT A uses default parameters, DUT B uses
// LOAD_STALL_CYCLES=3, FLUSH_CYCLES=2, PERF_W=3 to exercise the multi-cycle paths and saturation.
module tb_hazard_ctrl;

  localparam logic [3:0] PASS_C  = 4'b1100;
  localparam logic [3:0] STALL_C = 4'b0001;
  localparam logic [3:0] FLUSH_C = 4'b1111;
  localparam int DUT_A = 0;
  localparam int DUT_B = 1;

  typedef struct {
    int          which;
    logic [3:0]  ctl;
    logic [15:0] perf;
    string       name;
  } exp_t;

  logic       CLK = 1'b1;
  logic       rst_a_n, rst_b_n;
  logic [4:0] rs_id, rt_id, wreg_ex, wreg_mem;
  logic       uses_rt_id, regwrite_ex, memread_ex, regwrite_mem, redirect_ex;

  logic        pc_a, ifw_a, fl_a, bub_a;
  logic [15:0] perf_a;
  logic        pc_b, ifw_b, fl_b, bub_b;
  logic [2:0]  perf_b;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl dut_a (
    .CLK(CLK), .RSTn(rst_a_n),
    .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .Wreg_addr_ex(wreg_ex), .RegWrite_ex(regwrite_ex), .MemRead_ex(memread_ex),
    .Wreg_addr_mem(wreg_mem), .RegWrite_mem(regwrite_mem), .redirect_ex(redirect_ex),
    .PC_write(pc_a), .IFID_write(ifw_a), .IFID_flush(fl_a), .IDEX_bubble(bub_a),
    .stall_cycles(perf_a)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .PERF_W(3)) dut_b (
    .CLK(CLK), .RSTn(rst_b_n),
    .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .Wreg_addr_ex(wreg_ex), .RegWrite_ex(regwrite_ex), .MemRead_ex(memread_ex),
    .Wreg_addr_mem(wreg_mem), .RegWrite_mem(regwrite_mem), .redirect_ex(redirect_ex),
    .PC_write(pc_b), .IFID_write(ifw_b), .IFID_flush(fl_b), .IDEX_bubble(bub_b),
    .stall_cycles(perf_b)
  );

  task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] wex, input logic rwex, input logic mrex,
                       input logic [4:0] wmem, input logic rwmem, input logic redir);
    rs_id = rs; rt_id = rt; uses_rt_id = urt;
    wreg_ex = wex; regwrite_ex = rwex; memread_ex = mrex;
    wreg_mem = wmem; regwrite_mem = rwmem; redirect_ex = redir;
  endtask

  task automatic idle();
    setIn(5'd1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // lw $2 sitting in EX while the ID instruction reads $2 through rs.
  task automatic loadUse();
    setIn(5'd2, 5'd3, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
  endtask

  // Inputs are already set; record what the chosen DUT must show this cycle, then advance.
  task automatic applyStimulus(input int which, input logic [3:0] ctl,
                               input logic [15:0] perf, input string name);
    exp_t e;
    e.which = which;
    e.ctl   = ctl;
    e.perf  = perf;
    e.name  = name;
    sb.push_back(e);
    @(negedge CLK);
    #1;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [3:0]  act_ctl;
    logic [15:0] act_perf;
    if (e.which == DUT_A) begin
      act_ctl  = {pc_a, ifw_a, fl_a, bub_a};
      act_perf = perf_a;
    end else begin
      act_ctl  = {pc_b, ifw_b, fl_b, bub_b};
      act_perf = {13'd0, perf_b};
    end
    checks++;
    if (act_ctl !== e.ctl || act_perf !== e.perf) begin
      failures++;
      $display("[TB] FAIL %s: got ctl=%b perf=%0d, expected ctl=%b perf=%0d",
               e.name, act_ctl, act_perf, e.ctl, e.perf);
    end
  endtask

  // Monitor: outputs are valid every cycle, sampled on posedge, away from the negedge state update.
  initial begin
    forever begin
      @(posedge CLK);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    loadUse();
    @(negedge CLK);
    #1;
    applyStimulus(DUT_A, PASS_C, 16'd0, "reset_masks_hz");

    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    idle();
    applyStimulus(DUT_A, PASS_C, 16'd0, "idle_after_reset");

    loadUse();
    applyStimulus(DUT_A, STALL_C, 16'd0, "lw_use_rs");
    idle();
    applyStimulus(DUT_A, PASS_C, 16'd1, "one_stall_then_run");
    setIn(5'd0, 5'd3, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    applyStimulus(DUT_A, PASS_C, 16'd1, "load_dest_zero");
    setIn(5'd5, 5'd2, 1'b0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    applyStimulus(DUT_A, PASS_C, 16'd1, "rt_not_used");
    setIn(5'd5, 5'd2, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    applyStimulus(DUT_A, STALL_C, 16'd1, "lw_use_rt");
    idle();
    applyStimulus(DUT_A, PASS_C, 16'd2, "run_after_rt_stall");

    loadUse();
    redirect_ex = 1'b1;
    applyStimulus(DUT_A, FLUSH_C, 16'd2, "redirect_beats_hz");
    idle();
    applyStimulus(DUT_A, PASS_C, 16'd2, "flush_one_cycle");

    setIn(5'd4, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    applyStimulus(DUT_A, STALL_C, 16'd2, "alu_ex_and_mem_match");
    setIn(5'd4, 5'd3, 1'b1, 5'd4, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    applyStimulus(DUT_A, STALL_C, 16'd3, "producer_in_mem");
    setIn(5'd4, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    applyStimulus(DUT_A, PASS_C, 16'd4, "producer_retired");
    setIn(5'd1, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0);
    applyStimulus(DUT_A, PASS_C, 16'd4, "mem_rt_unused");

    idle();
    rst_b_n = 1'b0;
    applyStimulus(DUT_B, PASS_C, 16'd0, "b_reset");
    rst_b_n = 1'b1;
    loadUse();
    applyStimulus(DUT_B, STALL_C, 16'd0, "b_stall1");
    idle();
    applyStimulus(DUT_B, STALL_C, 16'd1, "b_stall2");
    applyStimulus(DUT_B, STALL_C, 16'd2, "b_stall3");
    applyStimulus(DUT_B, PASS_C, 16'd3, "b_run_after_3");

    loadUse();
    applyStimulus(DUT_B, STALL_C, 16'd3, "b_stall_again");
    idle();
    redirect_ex = 1'b1;
    applyStimulus(DUT_B, FLUSH_C, 16'd4, "b_redirect_in_stall");
    redirect_ex = 1'b0;
    applyStimulus(DUT_B, FLUSH_C, 16'd4, "b_flush_hold");
    applyStimulus(DUT_B, PASS_C, 16'd4, "b_flush_done");

    redirect_ex = 1'b1;
    applyStimulus(DUT_B, FLUSH_C, 16'd4, "b_redirect_run");
    applyStimulus(DUT_B, FLUSH_C, 16'd4, "b_redirect_in_flush");
    redirect_ex = 1'b0;
    applyStimulus(DUT_B, FLUSH_C, 16'd4, "b_flush_reloaded");
    applyStimulus(DUT_B, PASS_C, 16'd4, "b_run_after_reload");

    loadUse();
    applyStimulus(DUT_B, STALL_C, 16'd4, "b_sat_stall1");
    idle();
    applyStimulus(DUT_B, STALL_C, 16'd5, "b_sat_stall2");
    applyStimulus(DUT_B, STALL_C, 16'd6, "b_sat_stall3");
    applyStimulus(DUT_B, PASS_C, 16'd7, "b_perf_full");
    loadUse();
    applyStimulus(DUT_B, STALL_C, 16'd7, "b_sat_hold1");
    idle();
    applyStimulus(DUT_B, STALL_C, 16'd7, "b_sat_hold2");
    applyStimulus(DUT_B, STALL_C, 16'd7, "b_sat_hold3");
    applyStimulus(DUT_B, PASS_C, 16'd7, "b_perf_saturated");

    loadUse();
    applyStimulus(DUT_B, STALL_C, 16'd7, "b_stall_before_reset");
    rst_b_n = 1'b0;
    applyStimulus(DUT_B, PASS_C, 16'd0, "b_reset_mid_stall");
    rst_b_n = 1'b1;
    idle();
    applyStimulus(DUT_B, PASS_C, 16'd0, "b_run_after_reset");

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge CLK);
    end
    #1;
    if (sb.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
